// File: rtl/sid_pattern_seq.sv
// sid_pattern_seq: programmable NUM_CH-channel step sequencer feeding SID voice note/gate/trig.
// Optional macro SID_SEQ_SWING_EN adds a swing input (even steps longer, odd steps shorter).

module sid_seq_ch #(
  parameter int STEPS  = 16,
  parameter int STEP_W = 4,
  parameter int NOTE_W = 7,
  parameter int CNT_W  = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [STEP_W-1:0] wr_step,
  input  logic [NOTE_W:0]   wr_data,
  input  logic              play,
  input  logic              entry,
  input  logic [STEP_W-1:0] step,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [CNT_W-1:0]  gate_len,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic              trig
);
  logic [STEPS-1:0][NOTE_W:0] mem;
  logic [NOTE_W:0]            rd;
  logic                       cur_vld;

  // Flop memory: the entry read sees pre-write data, so a same-cycle write lands on the next visit.
  assign rd = mem[step];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '0;
    else
      for (int i = 0; i < STEPS; i++)
        if (wr && wr_step == STEP_W'(i)) mem[i] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note    <= '0;
      trig    <= 1'b0;
      cur_vld <= 1'b0;
    end else begin
      trig <= entry && rd[NOTE_W];
      if (entry) begin
        cur_vld <= rd[NOTE_W];
        if (rd[NOTE_W]) note <= rd[NOTE_W-1:0];
      end else if (!play) begin
        cur_vld <= 1'b0;
      end
    end
  end

  // counter==0 never gates, leaving a retrigger gap between consecutive valid steps.
  assign gate = play && cur_vld && (cnt != '0) && (cnt <= gate_len);
endmodule

module sid_pattern_seq #(
  parameter int NUM_CH   = 2,
  parameter int STEPS    = 16,
  parameter int STEP_W   = $clog2(STEPS),
  parameter int NOTE_W   = 7,
  parameter int PERIOD_W = 24,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic [PERIOD_W-1:0]        step_period,
  input  logic [STEP_W-1:0]          loop_end,
  input  logic [NUM_CH*PERIOD_W-1:0] gate_len,
`ifdef SID_SEQ_SWING_EN
  input  logic [PERIOD_W-1:0]        swing,
`endif
  input  logic                       wr_en,
  input  logic [CH_W-1:0]            wr_ch,
  input  logic [STEP_W-1:0]          wr_step,
  input  logic [NOTE_W:0]            wr_data,
  output logic [NUM_CH*NOTE_W-1:0]   note,
  output logic [NUM_CH-1:0]          gate,
  output logic [NUM_CH-1:0]          trig,
  output logic [STEP_W-1:0]          step,
  output logic                       step_tick
);
  // One extra counter bit so a swung even step (period + swing) cannot overflow.
  localparam int CNT_W = PERIOD_W + 1;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t                         state, state_nx;
  logic [CNT_W-1:0]               cnt, cnt_nx, step_end;
  logic [STEP_W-1:0]              step_nx, eff_end;
  logic                           play, entry, wr_ok;
  logic [NUM_CH-1:0][NOTE_W-1:0]  note_a;

  assign play      = (state == PLAY);
  assign step_tick = play && (cnt == '0);
  assign entry     = step_tick && run;
  assign eff_end   = ({1'b0, loop_end} > (STEP_W+1)'(STEPS-1)) ? STEP_W'(STEPS-1) : loop_end;
  assign wr_ok     = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH))
                           && ({1'b0, wr_step} < (STEP_W+1)'(STEPS));

`ifdef SID_SEQ_SWING_EN
  logic [PERIOD_W-1:0] swing_s;
  assign swing_s  = (swing > step_period) ? step_period : swing;
  assign step_end = step[0] ? CNT_W'(step_period) - CNT_W'(swing_s)
                            : CNT_W'(step_period) + CNT_W'(swing_s);
`else
  assign step_end = CNT_W'(step_period);
`endif

  // >= rather than == so a live shrink of the step length ends the step immediately.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    step_nx  = '0;
    case (state)
      IDLE: if (run) state_nx = PLAY;
      PLAY: begin
        if (!run) state_nx = IDLE;
        else if (cnt >= step_end) step_nx = (step >= eff_end) ? '0 : step + 1'b1;
        else begin
          cnt_nx  = cnt + 1'b1;
          step_nx = step;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      step  <= step_nx;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sid_seq_ch #(.STEPS(STEPS), .STEP_W(STEP_W), .NOTE_W(NOTE_W), .CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr_ok && (wr_ch == CH_W'(c))),
      .wr_step  (wr_step),
      .wr_data  (wr_data),
      .play     (play),
      .entry    (entry),
      .step     (step),
      .cnt      (cnt),
      .gate_len ({1'b0, gate_len[c*PERIOD_W +: PERIOD_W]}),
      .note     (note_a[c]),
      .gate     (gate[c]),
      .trig     (trig[c])
    );
  end

  assign note = note_a;
endmodule

// File: tb/tb_sid_pattern_seq.sv
// Directed bench for sid_pattern_seq: reset, pattern playback, loop shrink, read-before-write, stop, period 0, swing.
module tb_sid_pattern_seq;
  localparam int NUM_CH = 2, STEPS = 16, STEP_W = 4, NOTE_W = 7, PERIOD_W = 24;

  logic                       clk = 1'b0;
  logic                       rst_n, run, wr_en;
  logic [PERIOD_W-1:0]        step_period;
  logic [STEP_W-1:0]          loop_end, wr_step, step;
  logic [NUM_CH*PERIOD_W-1:0] gate_len;
  logic [0:0]                 wr_ch;
  logic [NOTE_W:0]            wr_data;
  logic [NUM_CH*NOTE_W-1:0]   note;
  logic [NUM_CH-1:0]          gate, trig;
  logic                       step_tick;
  logic [NOTE_W-1:0]          n0, n1;
`ifdef SID_SEQ_SWING_EN
  logic [PERIOD_W-1:0]        swing;
`endif

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  assign n0 = note[NOTE_W-1:0];
  assign n1 = note[2*NOTE_W-1:NOTE_W];

  sid_pattern_seq #(.NUM_CH(NUM_CH), .STEPS(STEPS), .NOTE_W(NOTE_W), .PERIOD_W(PERIOD_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step_period(step_period), .loop_end(loop_end),
    .gate_len(gate_len),
`ifdef SID_SEQ_SWING_EN
    .swing(swing),
`endif
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_step(wr_step), .wr_data(wr_data),
    .note(note), .gate(gate), .trig(trig), .step(step), .step_tick(step_tick)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int st, input int v, input int nt);
    wr_en = 1'b1; wr_ch = ch[0]; wr_step = st[STEP_W-1:0]; wr_data = {v[0], nt[NOTE_W-1:0]};
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; step_period = 24'd9; loop_end = 4'd3;
    gate_len = {24'd20, 24'd4}; wr_en = 1'b0; wr_ch = 1'b0; wr_step = '0; wr_data = '0;
`ifdef SID_SEQ_SWING_EN
    swing = '0;
`endif
    repeat (3) tick();
    checks++; if (note !== '0) begin errs++; $display("FAIL rst_note got %0h exp 0", note); end
    checks++; if (gate !== '0) begin errs++; $display("FAIL rst_gate got %0b exp 0", gate); end
    checks++; if (trig !== '0) begin errs++; $display("FAIL rst_trig got %0b exp 0", trig); end
    checks++; if (step !== '0) begin errs++; $display("FAIL rst_step got %0d exp 0", step); end
    checks++; if (step_tick !== 1'b0) begin errs++; $display("FAIL rst_tick got %0b exp 0", step_tick); end
    rst_n = 1'b1;
    tick();
    checks++; if (step_tick !== 1'b1) begin errs++; $display("FAIL rel_tick got %0b exp 1", step_tick); end
    checks++; if (step !== '0) begin errs++; $display("FAIL rel_step got %0d exp 0", step); end
    checks++; if (gate !== '0) begin errs++; $display("FAIL rel_gate got %0b exp 0", gate); end
    run = 1'b0;
    tick();
    checks++; if (step_tick !== 1'b0) begin errs++; $display("FAIL idle_tick got %0b exp 0", step_tick); end
  endtask

  task automatic test_basic();
    logic [NOTE_W-1:0] e0, e1;
    logic v0, eg0, et0, eg1, et1;
    int c, s;
    e0 = '0; e1 = '0;
    wr(0, 0, 1, 22); wr(0, 3, 1, 17);
    for (int i = 0; i < 4; i++) wr(1, i, 1, 40 + i);
    run = 1'b1;
    tick();
    for (int k = 0; k < 42; k++) begin
      if (k > 0) tick();
      c = k % 10; s = (k / 10) % 4;
      v0  = (s == 0) || (s == 3);
      eg0 = v0 && (c >= 1) && (c <= 4);
      et0 = v0 && (c == 1);
      eg1 = (c != 0);
      et1 = (c == 1);
      if (et0) e0 = (s == 0) ? 7'd22 : 7'd17;
      if (et1) e1 = 7'(40 + s);
      checks++; if (step !== STEP_W'(s)) begin errs++; $display("FAIL basic_step k=%0d got %0d exp %0d", k, step, s); end
      checks++; if (step_tick !== (c == 0)) begin errs++; $display("FAIL basic_tick k=%0d got %0b exp %0b", k, step_tick, c == 0); end
      checks++; if (gate[0] !== eg0) begin errs++; $display("FAIL basic_gate0 k=%0d got %0b exp %0b", k, gate[0], eg0); end
      checks++; if (trig[0] !== et0) begin errs++; $display("FAIL basic_trig0 k=%0d got %0b exp %0b", k, trig[0], et0); end
      checks++; if (gate[1] !== eg1) begin errs++; $display("FAIL basic_gate1 k=%0d got %0b exp %0b", k, gate[1], eg1); end
      checks++; if (trig[1] !== et1) begin errs++; $display("FAIL basic_trig1 k=%0d got %0b exp %0b", k, trig[1], et1); end
      checks++; if (n0 !== e0) begin errs++; $display("FAIL basic_note0 k=%0d got %0d exp %0d", k, n0, e0); end
      checks++; if (n1 !== e1) begin errs++; $display("FAIL basic_note1 k=%0d got %0d exp %0d", k, n1, e1); end
    end
  endtask

  // Continues from step 0 counter 1 of the basic run.
  task automatic test_loop_shrink();
    loop_end = 4'd7;
    repeat (49) tick();
    checks++; if (step !== 4'd5 || step_tick !== 1'b1) begin errs++; $display("FAIL shrink_at5 got step %0d tick %0b exp 5 1", step, step_tick); end
    repeat (2) tick();
    loop_end = 4'd2;
    repeat (7) tick();
    checks++; if (step !== 4'd5 || step_tick !== 1'b0) begin errs++; $display("FAIL shrink_end5 got step %0d tick %0b exp 5 0", step, step_tick); end
    tick();
    checks++; if (step !== 4'd0 || step_tick !== 1'b1) begin errs++; $display("FAIL shrink_wrap got step %0d tick %0b exp 0 1", step, step_tick); end
    loop_end = 4'd3;
  endtask

  task automatic test_rbw_stop();
    repeat (20) tick();
    checks++; if (step !== 4'd2 || step_tick !== 1'b1) begin errs++; $display("FAIL rbw_entry got step %0d tick %0b exp 2 1", step, step_tick); end
    wr(0, 2, 1, 30);
    checks++; if (n0 !== 7'd22) begin errs++; $display("FAIL rbw_note_old got %0d exp 22", n0); end
    checks++; if (trig[0] !== 1'b0) begin errs++; $display("FAIL rbw_trig_old got %0b exp 0", trig[0]); end
    checks++; if (gate[0] !== 1'b0) begin errs++; $display("FAIL rbw_gate_old got %0b exp 0", gate[0]); end
    repeat (40) tick();
    checks++; if (step !== 4'd2) begin errs++; $display("FAIL rbw_revisit_step got %0d exp 2", step); end
    checks++; if (n0 !== 7'd30) begin errs++; $display("FAIL rbw_note_new got %0d exp 30", n0); end
    checks++; if (trig[0] !== 1'b1) begin errs++; $display("FAIL rbw_trig_new got %0b exp 1", trig[0]); end
    checks++; if (gate[0] !== 1'b1) begin errs++; $display("FAIL rbw_gate_new got %0b exp 1", gate[0]); end
    tick();
    checks++; if (gate[0] !== 1'b1 || trig[0] !== 1'b0) begin errs++; $display("FAIL rbw_midgate got gate %0b trig %0b exp 1 0", gate[0], trig[0]); end
    run = 1'b0;
    tick();
    checks++; if (gate !== 2'b00) begin errs++; $display("FAIL stop_gate got %0b exp 00", gate); end
    checks++; if (trig !== 2'b00) begin errs++; $display("FAIL stop_trig got %0b exp 00", trig); end
    checks++; if (step !== 4'd0 || step_tick !== 1'b0) begin errs++; $display("FAIL stop_step got step %0d tick %0b exp 0 0", step, step_tick); end
    checks++; if (n0 !== 7'd30 || n1 !== 7'd42) begin errs++; $display("FAIL stop_notes got %0d %0d exp 30 42", n0, n1); end
    run = 1'b1;
    tick();
    checks++; if (step !== 4'd0 || step_tick !== 1'b1) begin errs++; $display("FAIL restart got step %0d tick %0b exp 0 1", step, step_tick); end
    tick();
    checks++; if (trig[0] !== 1'b1 || n0 !== 7'd22) begin errs++; $display("FAIL restart_trig got trig %0b note %0d exp 1 22", trig[0], n0); end
  endtask

  // ch0 pattern is now valid on steps 0, 2, 3; ch1 valid on 0..3.
  task automatic test_period0();
    logic et0;
    int p;
    run = 1'b0;
    tick();
    step_period = '0; run = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      if (j > 0) tick();
      p = (j + 3) % 4;
      et0 = (j >= 1) && (p != 1);
      checks++; if (step !== STEP_W'(j % 4)) begin errs++; $display("FAIL p0_step j=%0d got %0d exp %0d", j, step, j % 4); end
      checks++; if (step_tick !== 1'b1) begin errs++; $display("FAIL p0_tick j=%0d got %0b exp 1", j, step_tick); end
      checks++; if (gate !== 2'b00) begin errs++; $display("FAIL p0_gate j=%0d got %0b exp 00", j, gate); end
      checks++; if (trig[1] !== (j >= 1)) begin errs++; $display("FAIL p0_trig1 j=%0d got %0b exp %0b", j, trig[1], j >= 1); end
      checks++; if (trig[0] !== et0) begin errs++; $display("FAIL p0_trig0 j=%0d got %0b exp %0b", j, trig[0], et0); end
    end
  endtask

`ifdef SID_SEQ_SWING_EN
  task automatic test_swing();
    run = 1'b0; tick();
    step_period = 24'd9; swing = 24'd3; run = 1'b1;
    tick();
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 12 || j == 19) begin
        checks++; if (step_tick !== 1'b0) begin errs++; $display("FAIL sw3_tick j=%0d got %0b exp 0", j, step_tick); end
      end
      if (j == 13) begin
        checks++; if (step_tick !== 1'b1 || step !== 4'd1) begin errs++; $display("FAIL sw3_s1 got tick %0b step %0d exp 1 1", step_tick, step); end
      end
      if (j == 20) begin
        checks++; if (step_tick !== 1'b1 || step !== 4'd2) begin errs++; $display("FAIL sw3_s2 got tick %0b step %0d exp 1 2", step_tick, step); end
      end
    end
    run = 1'b0; tick();
    swing = 24'd50; run = 1'b1;
    tick();
    for (int j = 1; j <= 39; j++) begin
      tick();
      if (j == 18 || j == 21 || j == 38) begin
        checks++; if (step_tick !== 1'b0) begin errs++; $display("FAIL sw50_tick j=%0d got %0b exp 0", j, step_tick); end
      end
      if (j == 19 || j == 20 || j == 39) begin
        checks++; if (step_tick !== 1'b1 || step !== STEP_W'(j == 19 ? 1 : (j == 20 ? 2 : 3)))
          begin errs++; $display("FAIL sw50_step j=%0d got tick %0b step %0d", j, step_tick, step); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_loop_shrink();
    test_rbw_stop();
    test_period0();
`ifdef SID_SEQ_SWING_EN
    test_swing();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sid_pattern_seq.md
Name: sid_pattern_seq

Overview:
- Programmable multi-channel step sequencer: the parametrised successor to the fixed-ROM drum/bass sequencer.
- Pattern memory is written at run time; step period, loop length and per-channel gate length are inputs.
- Drives NUM_CH SID voice note/gate inputs. Sits between the control/register interface and the voice array.

Parameters:
NUM_CH, 2, number of independent sequencer channels (voices)
STEPS, 16, pattern length in steps (power of two not required)
STEP_W, $clog2(STEPS), step index width
NOTE_W, 7, note/frequency word width per channel
PERIOD_W, 24, step-period counter width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
run  in  1  level: 1=play, 0=stop
step_period  in  PERIOD_W  step length = step_period+1 clocks
loop_end  in  STEP_W  last step played before wrap to 0
gate_len  in  NUM_CH*PERIOD_W  per-channel gate length in clocks, channel c at [c*PERIOD_W +: PERIOD_W]
wr_en  in  1  pattern write strobe
wr_ch  in  $clog2(NUM_CH) (min 1)  channel to write
wr_step  in  STEP_W  step to write
wr_data  in  NOTE_W+1  {valid, note}; valid=0 is a rest
note  out  NUM_CH*NOTE_W  current note per channel
gate  out  NUM_CH  voice gate per channel
trig  out  NUM_CH  1-cycle note-on pulse per channel
step  out  STEP_W  current step index
step_tick  out  1  1-cycle pulse on every step entry

Behaviour:
- Reset (async, rst_n=0): note=0, gate=0, trig=0, step=0, step_tick=0, counter=0, state=IDLE. All pattern valid bits cleared; note fields cleared. Memory is flops.
- States: IDLE, PLAY.
  - IDLE→PLAY on run=1. The first PLAY cycle is the step-0 entry cycle.
  - PLAY→IDLE on run=0. On the next edge gate=0, trig=0, counter=0, step=0. Notes hold.
- Counter runs 0..step_period inclusive. The cycle with counter==0 is the step entry cycle.
- Advance occurs when counter>=step_period, so a live decrease of step_period takes effect immediately. Next step: 0 if step>=eff_loop_end, else step+1.
- eff_loop_end = min(loop_end, STEPS-1). A live change below the current step wraps to 0 at the next boundary.
- Entry cycle, per channel c:
  - Entry data is read combinationally: memory[c][step].
  - If valid: note_c<=entry.note and trig_c=1 on the cycle after entry, aligned with the gate rise.
  - If rest: note_c holds and there is no trig.
  - step_tick=1 in the entry cycle itself.
- Gate, per channel:
  - gate_c=1 while 1<=counter<=gate_len_c and the current entry is valid.
  - gate is always 0 when counter==0, which guarantees a ≥1-cycle retrigger gap between consecutive valid steps.
  - gate_len_c=0 gives trig with no gate. gate_len_c>=step_period holds the gate to the step end.
  - Valid is latched at entry, so a later write to the same address does not change the current step.
- Writes: synchronous, when wr_en=1 and wr_ch<NUM_CH (out-of-range writes are ignored). wr_step>=STEPS is ignored.
  - Write to the current step during its entry cycle: old data is used (read-before-write). New data plays on the next visit.
- Writes are accepted in IDLE and PLAY.
- step_period=0: every cycle is an entry cycle and gate never asserts. This case is legal.
- run toggled 1→0→1: playback restarts from step 0. There is no resume.

Optional Feature:
SID_SEQ_SWING_EN
- Defined: adds input port swing (PERIOD_W).
  - Even steps last step_period+1+s clocks and odd steps last step_period+1-s clocks, where s=min(swing, step_period).
  - Pair length is unchanged. The gate rules use the adjusted step end.
- Undefined: no swing port, and all steps last step_period+1 clocks.

Test Plan:
- Reset with run=1 held, then release rst_n → first cycle after release is step-0 entry, step_tick=1, gate=0; all outputs were 0 during reset.
- Write ch0 steps 0,3 = {1,22}, {1,17}; step_period=9, loop_end=3, gate_len0=4, run=1 →
  - trig0 at step 0 and step 3 only;
  - gate0 high for 4 clocks from counter 1;
  - note0=22, then 17;
  - step sequence 0,1,2,3,0 with a 10-clock period.
- ch1 every step valid, gate_len1=20, step_period=9 → gate1 low exactly 1 cycle at each entry, trig1 every step.
- Playing at step 5, set loop_end=2 → next step is 0.
- Write step 2 ch0 {1,30} in step 2's entry cycle → current note unchanged; 30 plays on the next visit. Also drop run mid-gate → gate=0 next cycle, step=0.
- SID_SEQ_SWING_EN, step_period=9, swing=3 → step lengths alternate 13, 7. With swing=50 → lengths 19, 1.
